// File: rtl/io_pkg.sv
// io_pkg: constants and helpers shared by the memory-mapped input bank.
// Holds the default base select, the register offsets past the data
// registers, and a constant-foldable clog2 used to size the debounce counters.
package io_pkg;

   // addr[7:2] of data register 0 in the default I/O map
   localparam logic [5:0] IO_BASE_SEL = 6'b110000;

   // STATUS sits directly after the last data register
   function automatic int status_ofs(input int num_ports);
      return num_ports;
   endfunction

   // IRQ_MASK sits directly after STATUS
   function automatic int mask_ofs(input int num_ports);
      return num_ports + 1;
   endfunction

   // Smallest r with 2**r >= value (0 for value <= 1)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/io_input_chan.sv
// io_input_chan: one input port of the bank.
// Two-flop synchroniser feeding a data register, plus change detection.
// chg_pulse_o is high for the cycle whose posedge loads a value that differs
// from the current data register, so the parent can set its sticky flag on
// that same edge.
// Optional debounce: define IO_INPUT_DEBOUNCE_EN. A per-port counter then
// requires the synchronised value to differ from the data register and stay
// stable for DEBOUNCE_CYC consecutive evaluations before it is accepted.
module io_input_chan
   import io_pkg::*;
#(
   parameter int PORT_W       = 8,
   parameter int DEBOUNCE_CYC = 16
)
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [PORT_W-1:0] pin_i,
   output logic [PORT_W-1:0] data_o,
   output logic              chg_pulse_o
);

   logic [PORT_W-1:0] sync1_q;
   logic [PORT_W-1:0] sync2_q;
   logic [PORT_W-1:0] data_q;
   logic [PORT_W-1:0] data_d;
   logic              load;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef IO_INPUT_DEBOUNCE_EN
   localparam int                CNT_W    = clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count stable cycles of a differing value. sync1 != sync2 means sync2
   // changes on this edge, so the run restarts; a value equal to the data
   // register also restarts it. The last count accepts the value.
   always_comb begin
      cnt_d = '0;
      load  = 1'b0;
      if ((sync2_q != data_q) && (sync1_q == sync2_q)) begin
         if (cnt_q == CNT_LAST) begin
            load = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce counter state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Without debounce the data register simply follows sync2 every cycle
   localparam int unused_debounce_cyc = DEBOUNCE_CYC;
   assign load = 1'b1;
`endif

   assign data_d      = load ? sync2_q : data_q;
   assign chg_pulse_o = load && (sync2_q != data_q);
   assign data_o      = data_q;

   // Data register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped input block for the CPU I/O space.
// NUM_PORTS synchronised input ports, each readable as a data register,
// a read-to-clear STATUS register of sticky change flags, a read/write
// IRQ_MASK register and a level interrupt (flag & mask, OR-reduced).
// Registers are word selected by addr[7:2] starting at BASE_SEL.
// Optional debounce: define IO_INPUT_DEBOUNCE_EN (handled in io_input_chan).
module io_input_bank
   import io_pkg::*;
#(
   parameter int         NUM_PORTS    = 4,
   parameter int         PORT_W       = 8,
   parameter logic [5:0] BASE_SEL     = IO_BASE_SEL,
   parameter int         DEBOUNCE_CYC = 16
)
(
   input  logic                        io_clk,
   input  logic                        io_clrn,
   input  logic [31:0]                 addr,
   input  logic                        io_rd,
   input  logic                        io_wr,
   input  logic [31:0]                 io_wdata,
   input  logic [NUM_PORTS*PORT_W-1:0] in_port,
   output logic [31:0]                 io_read_data,
   output logic                        io_irq
);

   localparam logic [5:0] STATUS_SEL = 6'(int'(BASE_SEL) + status_ofs(NUM_PORTS));
   localparam logic [5:0] MASK_SEL   = 6'(int'(BASE_SEL) + mask_ofs(NUM_PORTS));

   logic [5:0]                       sel;
   logic [NUM_PORTS-1:0][PORT_W-1:0] port_data;
   logic [NUM_PORTS-1:0]             chg_pulse;
   logic [NUM_PORTS-1:0]             chg_flag_q;
   logic [NUM_PORTS-1:0]             chg_flag_d;
   logic [NUM_PORTS-1:0]             irq_mask_q;
   logic [NUM_PORTS-1:0]             irq_mask_d;
   logic [NUM_PORTS-1:0]             flag_clr;
   logic                             status_rd;
   logic                             mask_wr;
   logic                             unused_bus_bits;

   assign sel       = addr[7:2];
   assign status_rd = io_rd && (sel == STATUS_SEL);
   assign mask_wr   = io_wr && (sel == MASK_SEL);

   // Only addr[7:2] and the mask bits of the write data carry meaning here
   assign unused_bus_bits = ^{addr[31:8], addr[1:0], io_wdata[31:NUM_PORTS]};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
         io_input_chan #(
            .PORT_W       (PORT_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_chan (
            .clk_i       (io_clk),
            .rst_ni      (io_clrn),
            .pin_i       (in_port[gi*PORT_W +: PORT_W]),
            .data_o      (port_data[gi]),
            .chg_pulse_o (chg_pulse[gi])
         );
      end
   endgenerate

   // Flag and mask next state: a STATUS read clears exactly the flags it
   // returned, and a coincident change pulse re-sets (set wins)
   always_comb begin
      flag_clr   = status_rd ? chg_flag_q : '0;
      chg_flag_d = (chg_flag_q & ~flag_clr) | chg_pulse;
      irq_mask_d = mask_wr ? io_wdata[NUM_PORTS-1:0] : irq_mask_q;
   end

   // Sticky change flags and interrupt mask
   always_ff @(posedge io_clk or negedge io_clrn) begin
      if (!io_clrn) begin
         chg_flag_q <= '0;
         irq_mask_q <= '0;
      end else begin
         chg_flag_q <= chg_flag_d;
         irq_mask_q <= irq_mask_d;
      end
   end

   // Fully decoded read mux, zero for unmapped selects
   always_comb begin
      io_read_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sel == 6'(int'(BASE_SEL) + i)) begin
            io_read_data = 32'(port_data[i]);
         end
      end
      if (sel == STATUS_SEL) begin
         io_read_data = 32'(chg_flag_q);
      end
      if (sel == MASK_SEL) begin
         io_read_data = 32'(irq_mask_q);
      end
   end

   assign io_irq = |(chg_flag_q & irq_mask_q);

endmodule
